// File: rtl/rv32_pkg.sv
// Shared RV32I constants and types for the memory stage: opcodes, load/store funct3
// encodings, the memory-stage FSM state type and the canonical NOP.
package rv32_pkg;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpOp    = 7'b0110011;
    localparam logic [6:0] OpOpImm = 7'b0010011;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    localparam logic [31:0] InstrNop = 32'h00000013;

    typedef enum logic {StIdle, StWait} mem_state_t;

    // Unknown opcodes fall through to default, so X instructions never access memory.
    function automatic logic is_mem_op(input logic [6:0] op);
        case (op)
            OpLoad, OpStore: is_mem_op = 1'b1;
            default:         is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OpLui, OpAuipc, OpJal, OpJalr, OpOp, OpOpImm, OpLoad: writes_rd = 1'b1;
            default:                                              writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_ctl_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory.
interface memory_ctl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables / replicated data, address alignment,
// misalignment detection and load lane extraction with sign or zero extension.
module mem_align
    import rv32_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] req_addr,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] rdata,
    output logic [31:0] ld_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Loads and stores share the width encoding in funct3[1:0].
    always_comb begin
        req_addr   = addr;
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        case (size)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                req_addr   = {addr[31:1], 1'b0};
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
            end
            default: begin
                misaligned = |addr[1:0];
                req_addr   = {addr[31:2], 2'b00};
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata[{ld_lane, 3'b000} +: 8];
        half_sel = ld_lane[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3Lb:    ld_value = {{24{byte_sel[7]}}, byte_sel};
            F3Lh:    ld_value = {{16{half_sel[15]}}, half_sel};
            F3Lbu:   ld_value = {24'h000000, byte_sel};
            F3Lhu:   ld_value = {16'h0000, half_sel};
            default: ld_value = rdata;
        endcase
    end

endmodule

// File: rtl/memory_ctl.sv
// RV32I memory stage: runs the data-memory handshake, stalls the front end while an access
// is outstanding and registers the writeback bundle. MEM_MISALIGN_TRAP_EN suppresses
// misaligned accesses instead of forcing them aligned.
module memory_ctl
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  alu_result,
    input  logic [31:0]  data_b_exe,
    input  logic [31:0]  pc_exe,
    input  logic [31:0]  instr_exe,
    memory_ctl_if.master dmem,
    output logic         mem_stall,
    output logic         wb_we,
    output logic [4:0]   wb_rd,
    output logic [31:0]  wb_data,
    output logic [31:0]  pc_mem,
    output logic [31:0]  instr_mem,
    output logic         bus_err,
    output logic         misalign_err
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    mem_state_t  state_q;
    logic [15:0] cnt_q;
    logic [2:0]  ld_funct3_q;
    logic [4:0]  rd_q;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        is_mem;
    logic        is_jump;
    logic        trap;
    logic        timeout_hit;
    logic [31:0] req_addr;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        misaligned;
    logic [31:0] ld_value;

    assign opcode  = instr_exe[6:0];
    assign rd      = instr_exe[11:7];
    assign is_mem  = is_mem_op(opcode);
    assign is_jump = (opcode == OpJal) || (opcode == OpJalr);
    assign trap    = TrapEn && is_mem && misaligned;

    // Ack in the last permitted cycle takes priority over the timeout.
    assign timeout_hit = (state_q == StWait) && !dmem.dmem_ack && (cnt_q == TimeoutLast);

    mem_align u_mem_align (
        .size       (instr_exe[13:12]),
        .addr       (alu_result),
        .store_data (data_b_exe),
        .req_addr   (req_addr),
        .be         (be_next),
        .wdata      (wdata_next),
        .misaligned (misaligned),
        .ld_funct3  (ld_funct3_q),
        .ld_lane    (dmem.dmem_addr[1:0]),
        .rdata      (dmem.dmem_rdata),
        .ld_value   (ld_value)
    );

    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            StIdle:  mem_stall = is_mem && !trap;
            StWait:  mem_stall = !dmem.dmem_ack && !timeout_hit;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= 16'd0;
            ld_funct3_q     <= 3'b000;
            rd_q            <= 5'd0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'd0;
            dmem.dmem_be    <= 4'b0000;
            dmem.dmem_wdata <= 32'd0;
            wb_we           <= 1'b0;
            wb_rd           <= 5'd0;
            wb_data         <= 32'd0;
            pc_mem          <= 32'd0;
            instr_mem       <= InstrNop;
            bus_err         <= 1'b0;
            misalign_err    <= 1'b0;
        end else begin
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (is_mem && !trap) begin
                        state_q         <= StWait;
                        cnt_q           <= 16'd0;
                        ld_funct3_q     <= instr_exe[14:12];
                        rd_q            <= rd;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= (opcode == OpStore);
                        dmem.dmem_addr  <= req_addr;
                        dmem.dmem_be    <= be_next;
                        dmem.dmem_wdata <= wdata_next;
                        wb_we           <= 1'b0;
                    end else begin
                        wb_we        <= writes_rd(opcode) && (rd != 5'd0) && !trap;
                        wb_rd        <= rd;
                        wb_data      <= is_jump ? pc_exe + 32'd4 : alu_result;
                        pc_mem       <= pc_exe;
                        instr_mem    <= instr_exe;
                        misalign_err <= trap;
                    end
                end
                StWait: begin
                    if (dmem.dmem_ack) begin
                        state_q       <= StIdle;
                        dmem.dmem_req <= 1'b0;
                        wb_we         <= !dmem.dmem_we && (rd_q != 5'd0);
                        wb_rd         <= rd_q;
                        if (!dmem.dmem_we) begin
                            wb_data <= ld_value;
                        end
                        pc_mem    <= pc_exe;
                        instr_mem <= instr_exe;
                    end else if (timeout_hit) begin
                        state_q       <= StIdle;
                        dmem.dmem_req <= 1'b0;
                        bus_err       <= 1'b1;
                        wb_we         <= 1'b0;
                        pc_mem        <= pc_exe;
                        instr_mem     <= instr_exe;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        wb_we <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_ctl.sv
// Randomized self-checking bench for memory_ctl: a transaction-level model predicts each
// instruction's stall profile, memory request and writeback from the instruction fields.
module tb_memory_ctl;

    localparam int TO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, data_b_exe, pc_exe, instr_exe;
    logic        mem_stall, wb_we, bus_err, misalign_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, pc_mem, instr_mem;

    memory_ctl_if dmem_bus ();

    memory_ctl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result   (alu_result),
        .data_b_exe   (data_b_exe),
        .pc_exe       (pc_exe),
        .instr_exe    (instr_exe),
        .dmem         (dmem_bus),
        .mem_stall    (mem_stall),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .pc_mem       (pc_mem),
        .instr_mem    (instr_mem),
        .bus_err      (bus_err),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Values seen on the DUT during the last run_instr call.
    int          stall_cnt;
    logic        obs_req, obs_we, obs_wb_we, obs_bus_err, obs_mis;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata, obs_wb_data;
    logic [4:0]  obs_wb_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_is_mem(input logic [31:0] i);
        return (i[6:0] === 7'b0000011) || (i[6:0] === 7'b0100011);
    endfunction

    function automatic bit m_writes(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        return (op === 7'b0110111) || (op === 7'b0010111) || (op === 7'b1101111) ||
               (op === 7'b1100111) || (op === 7'b0110011) || (op === 7'b0010011) ||
               (op === 7'b0000011);
    endfunction

    function automatic bit m_misaligned(input logic [31:0] i, input logic [31:0] a);
        if (i[13:12] == 2'd1) return (a % 2) != 0;
        if (i[13:12] == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] i, input logic [31:0] a);
        if (i[13:12] == 2'd1) return a - (a % 2);
        if (i[13:12] == 2'd2) return a - (a % 4);
        return a;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] i, input logic [31:0] a);
        if (i[13:12] == 2'd0) return 4'(32'd1 << (a % 4));
        if (i[13:12] == 2'd1) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] i, input logic [31:0] d);
        if (i[13:12] == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (i[13:12] == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] i, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * (a % 4));
        case (i[14:12])
            3'd0:    return ((s & 32'hFF) ^ 32'h80) - 32'h80;
            3'd1:    return ((s & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            3'd4:    return s & 32'hFF;
            3'd5:    return s & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // Present one instruction from posedge+1 until it retires; ack_delay is the WAIT-cycle
    // index (0-based) at which the memory acknowledges, or out of range for no ack.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] alu,
                             input logic [31:0] db, input logic [31:0] pc,
                             input int ack_delay, input logic [31:0] rword);
        bit          mem, trapped, store, exp_we, ack;
        logic [4:0]  rd;
        logic [31:0] ea;
        mem     = m_is_mem(ins);
        trapped = TRAP && mem && m_misaligned(ins, alu);
        store   = (ins[6:0] === 7'b0100011);
        rd      = ins[11:7];
        ea      = m_addr(ins, alu);
        instr_exe = ins;
        alu_result = alu;
        data_b_exe = db;
        pc_exe = pc;
        dmem_bus.dmem_ack = 1'($urandom_range(0, 1));
        dmem_bus.dmem_rdata = $urandom;
        stall_cnt = 0;
        #1;
        check("stall_issue", mem_stall, mem && !trapped);
        if (mem_stall) stall_cnt++;
        @(posedge clk);
        #1;
        obs_req = dmem_bus.dmem_req;
        obs_mis = misalign_err;
        obs_addr = dmem_bus.dmem_addr;
        obs_be = dmem_bus.dmem_be;
        obs_wdata = dmem_bus.dmem_wdata;
        obs_we = dmem_bus.dmem_we;
        obs_wb_we = wb_we;
        obs_wb_rd = wb_rd;
        obs_wb_data = wb_data;
        obs_bus_err = bus_err;
        check("misalign_err", misalign_err, trapped);
        check("bus_err_idle", bus_err, 0);
        if (!mem || trapped) begin
            exp_we = !mem && m_writes(ins) && (rd != 5'd0);
            check("req_none", dmem_bus.dmem_req, 0);
            check("wb_we", wb_we, exp_we);
            if (exp_we) begin
                check("wb_rd", wb_rd, rd);
                check("wb_data", wb_data,
                      (ins[6:0] === 7'b1101111 || ins[6:0] === 7'b1100111) ? pc + 4 : alu);
            end
            check("pc_mem", pc_mem, pc);
            check("instr_mem", instr_mem, ins);
            return;
        end
        check("req_set", dmem_bus.dmem_req, 1);
        check("req_we", dmem_bus.dmem_we, store);
        check("req_addr", dmem_bus.dmem_addr, ea);
        if (store) begin
            check("req_be", dmem_bus.dmem_be, m_be(ins, alu));
            check("req_wdata", dmem_bus.dmem_wdata, m_wdata(ins, db));
        end
        check("wb_we_bubble", wb_we, 0);
        for (int w = 0; w < TO; w++) begin
            ack = (w == ack_delay);
            dmem_bus.dmem_ack = ack;
            dmem_bus.dmem_rdata = ack ? rword : $urandom;
            #1;
            check("stall_wait", mem_stall, !ack && (w != TO - 1));
            if (mem_stall) stall_cnt++;
            check("req_stable", dmem_bus.dmem_addr, ea);
            @(posedge clk);
            #1;
            obs_wb_we = wb_we;
            obs_wb_rd = wb_rd;
            obs_wb_data = wb_data;
            obs_bus_err = bus_err;
            check("req_after", dmem_bus.dmem_req, !(ack || (w == TO - 1)));
            if (ack) begin
                exp_we = !store && (rd != 5'd0);
                check("ld_wb_we", wb_we, exp_we);
                if (exp_we) begin
                    check("ld_wb_rd", wb_rd, rd);
                    check("ld_wb_data", wb_data, m_load(ins, ea, rword));
                end
                check("bus_err_ack", bus_err, 0);
                check("pc_mem_mem", pc_mem, pc);
                check("instr_mem_mem", instr_mem, ins);
                break;
            end else if (w == TO - 1) begin
                check("timeout_bus_err", bus_err, 1);
                check("timeout_wb_we", wb_we, 0);
                check("timeout_pc_mem", pc_mem, pc);
            end else begin
                check("wait_wb_we", wb_we, 0);
                check("wait_bus_err", bus_err, 0);
            end
        end
        dmem_bus.dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        logic [6:0]  op;
        int          k;
        rst = 1'b1;
        instr_exe = 32'h00000013;
        alu_result = 32'd0;
        data_b_exe = 32'd0;
        pc_exe = 32'd0;
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = 32'd0;
        #12;
        check("rst_req", dmem_bus.dmem_req, 0);
        check("rst_we", dmem_bus.dmem_we, 0);
        check("rst_be", dmem_bus.dmem_be, 4'b0000);
        check("rst_addr", dmem_bus.dmem_addr, 0);
        check("rst_wdata", dmem_bus.dmem_wdata, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_pc_mem", pc_mem, 0);
        check("rst_instr_mem", instr_mem, 32'h00000013);
        check("rst_bus_err", bus_err, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_stall", mem_stall, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_instr(32'h00000293, 32'h00001234, 32'd0, 32'h0, -1, 32'd0);
        check("addi_we", obs_wb_we, 1);
        check("addi_rd", obs_wb_rd, 5);
        check("addi_data", obs_wb_data, 32'h00001234);
        check("addi_stall", stall_cnt, 0);

        run_instr(32'h00000023, 32'h00001003, 32'h000000AB, 32'h4, 3, 32'd0);
        check("sb_be", obs_be, 4'b1000);
        check("sb_wdata", obs_wdata, 32'hABABABAB);
        check("sb_we", obs_we, 1);
        check("sb_stall_cycles", stall_cnt, 4);

        run_instr(32'h00000303, 32'h00002001, 32'd0, 32'h8, 0, 32'h00008000);
        check("lb_data", obs_wb_data, 32'hFFFFFF80);
        run_instr(32'h00004303, 32'h00002001, 32'd0, 32'hC, 1, 32'h00008000);
        check("lbu_data", obs_wb_data, 32'h00000080);

        run_instr(32'h000000EF, 32'h0, 32'd0, 32'h00000100, -1, 32'd0);
        check("jal_data", obs_wb_data, 32'h00000104);
        check("jal_rd", obs_wb_rd, 1);

        run_instr(32'h00002383, 32'h00000040, 32'd0, 32'h10, -1, 32'd0);
        check("lw_to_bus_err", obs_bus_err, 1);
        check("lw_to_wb_we", obs_wb_we, 0);
        run_instr(32'h00000293, 32'h00000055, 32'd0, 32'h14, -1, 32'd0);
        check("after_to_idle", stall_cnt, 0);

        run_instr(32'h00002383, 32'h00003002, 32'd0, 32'h18, 0, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lw_mis_err", obs_mis, 1);
        check("lw_mis_noreq", obs_req, 0);
`else
        check("lw_mis_addr", obs_addr, 32'h00003000);
        check("lw_mis_data", obs_wb_data, 32'hCAFEF00D);
`endif

        run_instr(32'hxxxxxxxx, 32'h00000077, 32'd0, 32'h1C, -1, 32'd0);

        // Asynchronous reset while an access is outstanding.
        instr_exe = 32'h00002383;
        alu_result = 32'h00000080;
        dmem_bus.dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        check("rstwait_req_before", dmem_bus.dmem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstwait_req_drop", dmem_bus.dmem_req, 0);
        check("rstwait_wb_we", wb_we, 0);
        instr_exe = 32'h00000013;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstwait_idle_req", dmem_bus.dmem_req, 0);

        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 12);
            case (k)
                0:       op = 7'b0110111;
                1:       op = 7'b0010111;
                2:       op = 7'b1101111;
                3:       op = 7'b1100111;
                4:       op = 7'b0110011;
                5:       op = 7'b0010011;
                6, 7, 8: op = 7'b0000011;
                9, 10:   op = 7'b0100011;
                11:      op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            if (k == 12 && (op == 7'b0000011 || op == 7'b0100011)) op = 7'b1100011;
            ins = $urandom;
            ins[6:0] = op;
            if (op == 7'b0000011) begin
                case ($urandom_range(0, 4))
                    0:       ins[14:12] = 3'd0;
                    1:       ins[14:12] = 3'd1;
                    2:       ins[14:12] = 3'd2;
                    3:       ins[14:12] = 3'd4;
                    default: ins[14:12] = 3'd5;
                endcase
            end else if (op == 7'b0100011) begin
                ins[14:12] = 3'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
            run_instr(ins, $urandom, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
